// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and pixel/colour logic.
//   en, resync          : run enable and restart pulse into the generator
//   pix_ce              : pixel clock-enable
//   hsync, vsync, de    : sync and display-enable levels
//   hcount, vcount      : raw raster position
//   x, y                : active-area coordinates (0 outside the active window)
//   line_start,
//   frame_start         : one-clk wrap strobes
// master = generator side, slave = consumer side.
interface vga_timing_gen_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic          en;
  logic          resync;
  logic          pix_ce;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  en, resync,
    output pix_ce, hsync, vsync, de, hcount, vcount, x, y, line_start, frame_start
  );

  modport slave (
    output en, resync,
    input  pix_ce, hsync, vsync, de, hcount, vcount, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator.
// Line order is sync -> back porch -> active -> front porch in both axes.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   tif    : vga_timing_gen_if.master (en/resync in, timing outputs out)
// Every output is a flop. Next-state values are decoded from the next raster
// position so hsync/de/x/y always describe the hcount/vcount they sit beside.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  tif
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_E  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_DE_BEG  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_DE_LAST = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_DE_BEG  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_DE_LAST = VW'(V_SYNC + V_BP + V_ACTIVE - 1);

  logic [DW-1:0] div, div_nxt;
  logic          pix_ce_q, pce_nxt;
  logic [HW-1:0] hcnt, h_nxt, x_q;
  logic [VW-1:0] vcnt, v_nxt, y_q;
  logic          hs_q, vs_q, de_q, ls_q, fs_q;
  logic          h_act, v_act;

  // pix_ce is registered one cycle ahead: it is raised on the edge that
  // brings div to its last value, so the counters step on the following edge.
  always_comb begin
    div_nxt = '0;
    if (tif.en && (div != DIV_LAST)) div_nxt = div + 1'b1;
    pce_nxt = tif.en && (div_nxt == DIV_LAST);

    h_nxt = hcnt;
    v_nxt = vcnt;
    if (pix_ce_q) begin
      if (hcnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        h_nxt = hcnt + 1'b1;
      end
    end

    h_act = (h_nxt >= H_DE_BEG) && (h_nxt <= H_DE_LAST);
    v_act = (v_nxt >= V_DE_BEG) && (v_nxt <= V_DE_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div      <= '0;
      pix_ce_q <= 1'b0;
      hcnt     <= '0;
      vcnt     <= '0;
      hs_q     <= HS_POL;
      vs_q     <= VS_POL;
      de_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else if (tif.resync) begin
      // Restart lands on the reset state; a resync never produces a strobe.
      div      <= '0;
      pix_ce_q <= 1'b0;
      hcnt     <= '0;
      vcnt     <= '0;
      hs_q     <= HS_POL;
      vs_q     <= VS_POL;
      de_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div      <= div_nxt;
      pix_ce_q <= pce_nxt;
      hcnt     <= h_nxt;
      vcnt     <= v_nxt;
      hs_q     <= (h_nxt < H_SYNC_E) ? HS_POL : ~HS_POL;
      vs_q     <= (v_nxt < V_SYNC_E) ? VS_POL : ~VS_POL;
      de_q     <= h_act && v_act;
      x_q      <= (h_act && v_act) ? h_nxt - H_DE_BEG : '0;
      y_q      <= (h_act && v_act) ? v_nxt - V_DE_BEG : '0;
      ls_q     <= pix_ce_q && (hcnt == H_LAST);
      fs_q     <= pix_ce_q && (hcnt == H_LAST) && (vcnt == V_LAST);
    end
  end

  assign tif.pix_ce      = pix_ce_q;
  assign tif.hsync       = hs_q;
  assign tif.vsync       = vs_q;
  assign tif.de          = de_q;
  assign tif.hcount      = hcnt;
  assign tif.vcount      = vcnt;
  assign tif.x           = x_q;
  assign tif.y           = y_q;
  assign tif.line_start  = ls_q;
  assign tif.frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance (CLK_DIV=2) and a
// 7x6 instance with positive syncs (CLK_DIV=1), both checked against a
// pixel-index reference model plus fixed-point expectations.
module tb_vga_timing_gen;
  typedef logic [69:0] ovec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vga_timing_gen_if #(.HW(10), .VW(10)) tifa();
  vga_timing_gen_if #(.HW(3),  .VW(3))  tifb();

  vga_timing_gen dut_a (.clk(clk), .reset(reset), .tif(tifa));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)
  ) dut_b (.clk(clk), .reset(reset), .tif(tifb));

  // Expected outputs from a linear pixel index, straight from the raster rules.
  function automatic ovec_t expv(int pos, bit pce, bit ls, bit fs,
                                 int hs, int hb, int ha, int hf,
                                 int vs, int vb, int va, bit hp, bit vp);
    int ht = hs + hb + ha + hf;
    int h  = pos % ht;
    int v  = pos / ht;
    bit de = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
    bit hl = (h < hs) ? hp : ~hp;
    bit vl = (v < vs) ? vp : ~vp;
    return {pce, hl, vl, de, 16'(h), 16'(v),
            de ? 16'(h - hs - hb) : 16'd0, de ? 16'(v - vs - vb) : 16'd0, ls, fs};
  endfunction

  // Reference model: pixel index, count of consecutive enabled clocks, strobes.
  localparam int AHT = 800, ATOT = 800 * 525, ADIV = 2;
  localparam int BHT = 7,   BTOT = 7 * 6,     BDIV = 1;
  int ma_pos, ma_run, mb_pos, mb_run;
  bit ma_pce, ma_ls, ma_fs, mb_pce, mb_ls, mb_fs;

  always @(posedge clk or posedge reset) begin
    if (reset || tifa.resync) begin
      ma_pos <= 0; ma_run <= 0; ma_pce <= 0; ma_ls <= 0; ma_fs <= 0;
    end else begin
      ma_ls <= ma_pce && (ma_pos % AHT == AHT - 1);
      ma_fs <= ma_pce && (ma_pos == ATOT - 1);
      if (ma_pce) ma_pos <= (ma_pos + 1) % ATOT;
      if (tifa.en) begin
        ma_run <= ma_run + 1;
        ma_pce <= ((ma_run + 1) % ADIV) == ADIV - 1;
      end else begin
        ma_run <= 0; ma_pce <= 0;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset || tifb.resync) begin
      mb_pos <= 0; mb_run <= 0; mb_pce <= 0; mb_ls <= 0; mb_fs <= 0;
    end else begin
      mb_ls <= mb_pce && (mb_pos % BHT == BHT - 1);
      mb_fs <= mb_pce && (mb_pos == BTOT - 1);
      if (mb_pce) mb_pos <= (mb_pos + 1) % BTOT;
      if (tifb.en) begin
        mb_run <= mb_run + 1;
        mb_pce <= ((mb_run + 1) % BDIV) == BDIV - 1;
      end else begin
        mb_run <= 0; mb_pce <= 0;
      end
    end
  end

  ovec_t eva, evb, dva, dvb;
  assign eva = expv(ma_pos, ma_pce, ma_ls, ma_fs, 96, 48, 640, 16, 2, 33, 480, 1'b0, 1'b0);
  assign evb = expv(mb_pos, mb_pce, mb_ls, mb_fs, 1, 1, 4, 1, 1, 1, 3, 1'b1, 1'b1);
  assign dva = {tifa.pix_ce, tifa.hsync, tifa.vsync, tifa.de, 16'(tifa.hcount), 16'(tifa.vcount),
                16'(tifa.x), 16'(tifa.y), tifa.line_start, tifa.frame_start};
  assign dvb = {tifb.pix_ce, tifb.hsync, tifb.vsync, tifb.de, 16'(tifb.hcount), 16'(tifb.vcount),
                16'(tifb.x), 16'(tifb.y), tifb.line_start, tifb.frame_start};

  task automatic test_reset();
    reset = 1'b1;
    tifa.en = 1'b0; tifa.resync = 1'b0;
    tifb.en = 1'b0; tifb.resync = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dva !== eva) begin errors++; $display("FAIL reset_model_a: got %h expected %h", dva, eva); end
    checks++; if (dva !== 70'd0) begin errors++; $display("FAIL reset_const_a: got %h expected 0", dva); end
    checks++; if ({tifb.hsync, tifb.vsync, tifb.de, tifb.pix_ce} !== 4'b1100)
      begin errors++; $display("FAIL reset_sync_b: got %b expected 1100", {tifb.hsync, tifb.vsync, tifb.de, tifb.pix_ce}); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (dva !== eva) begin errors++; $display("FAIL idle_a: got %h expected %h", dva, eva); end
  endtask

  task automatic test_line();
    int n = 0;
    bit got = 0;
    tifa.en = 1'b1; tifb.en = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      checks++; if (dva !== eva) begin errors++; $display("FAIL line_model: got %h expected %h", dva, eva); end
      if (tifa.line_start) got = 1;
      else if (tifa.pix_ce) n++;
    end
    checks++; if (!got) begin errors++; $display("FAIL line_timeout: got no line_start expected one"); end
    checks++; if (n != 800) begin errors++; $display("FAIL line_pixces: got %0d expected 800", n); end
    checks++; if ({tifa.hcount, tifa.vcount} !== {10'd0, 10'd1})
      begin errors++; $display("FAIL line_pos: got %0d,%0d expected 0,1", tifa.hcount, tifa.vcount); end
  endtask

  task automatic test_freeze();
    bit got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      checks++; if (dva !== eva) begin errors++; $display("FAIL freeze_run: got %h expected %h", dva, eva); end
      if (tifa.hcount == 10'd300) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL freeze_timeout: got no hcount 300 expected it"); end
    tifa.en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++; if ({tifa.hcount, tifa.pix_ce, tifa.line_start} !== {10'd300, 2'b00})
        begin errors++; $display("FAIL freeze_hold: got h=%0d ce=%b expected h=300 ce=0", tifa.hcount, tifa.pix_ce); end
      checks++; if (dva !== eva) begin errors++; $display("FAIL freeze_model: got %h expected %h", dva, eva); end
    end
    tifa.en = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tifa.hcount !== 10'd301) begin errors++; $display("FAIL freeze_resume: got %0d expected 301", tifa.hcount); end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 3000; i++) begin
      tifa.en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++; if (dva !== eva) begin errors++; $display("FAIL rand_en: got %h expected %h", dva, eva); end
    end
    tifa.en = 1'b1;
  endtask

  task automatic test_resync();
    bit got = 0;
    int n = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (tifa.hcount == 10'd500) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL resync_timeout: got no hcount 500 expected it"); end
    tifa.resync = 1'b1;
    @(negedge clk);
    tifa.resync = 1'b0;
    checks++; if (dva !== 70'd0) begin errors++; $display("FAIL resync_state: got %h expected 0", dva); end
    checks++; if (dva !== eva) begin errors++; $display("FAIL resync_model: got %h expected %h", dva, eva); end
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      checks++; if (dva !== eva) begin errors++; $display("FAIL resync_run: got %h expected %h", dva, eva); end
      if (tifa.line_start) got = 1;
      else if (tifa.pix_ce) n++;
    end
    checks++; if (!got || n != 800) begin errors++; $display("FAIL resync_line: got %0d pix_ce expected 800", n); end
  endtask

  task automatic test_de_window();
    bit got = 0;
    for (int i = 0; i < 60000 && !got; i++) begin
      @(negedge clk);
      checks++; if (dva !== eva) begin errors++; $display("FAIL de_run: got %h expected %h", dva, eva); end
      if (tifa.hcount == 10'd144 && tifa.vcount == 10'd35) got = 1;
    end
    checks++; if (!got || {tifa.de, tifa.x, tifa.y} !== {1'b1, 10'd0, 10'd0})
      begin errors++; $display("FAIL de_first: got de=%b x=%0d y=%0d expected 1,0,0", tifa.de, tifa.x, tifa.y); end
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (tifa.hcount == 10'd783) got = 1;
    end
    checks++; if (!got || {tifa.de, tifa.x, tifa.y} !== {1'b1, 10'd639, 10'd0})
      begin errors++; $display("FAIL de_last: got de=%b x=%0d y=%0d expected 1,639,0", tifa.de, tifa.x, tifa.y); end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (tifa.hcount == 10'd784) got = 1;
    end
    checks++; if (!got || {tifa.de, tifa.x} !== {1'b0, 10'd0})
      begin errors++; $display("FAIL de_fp: got de=%b x=%0d expected 0,0", tifa.de, tifa.x); end
  endtask

  task automatic test_small();
    int last = -1, nfs = 0, hits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++; if (dvb !== evb) begin errors++; $display("FAIL small_model: got %h expected %h", dvb, evb); end
      if (tifb.frame_start) begin
        if (last >= 0) begin
          checks++; if (i - last != 42) begin errors++; $display("FAIL small_frame: got %0d clk expected 42", i - last); end
        end
        last = i; nfs++;
      end
      if (tifb.hcount == 3'd2 && tifb.vcount == 3'd2) begin
        hits++;
        checks++; if ({tifb.de, tifb.x, tifb.y, tifb.hsync, tifb.vsync} !== {1'b1, 3'd0, 3'd0, 2'b00})
          begin errors++; $display("FAIL small_de_first: got %b expected 1000000", {tifb.de, tifb.x, tifb.y}); end
      end
      if (tifb.hcount == 3'd5 && tifb.vcount == 3'd4) begin
        checks++; if ({tifb.de, tifb.x, tifb.y} !== {1'b1, 3'd3, 3'd2})
          begin errors++; $display("FAIL small_de_last: got de=%b x=%0d y=%0d expected 1,3,2", tifb.de, tifb.x, tifb.y); end
      end
      if (tifb.hcount == 3'd0 && tifb.vcount == 3'd0) begin
        checks++; if ({tifb.hsync, tifb.vsync, tifb.de} !== 3'b110)
          begin errors++; $display("FAIL small_sync: got %b expected 110", {tifb.hsync, tifb.vsync, tifb.de}); end
      end
    end
    checks++; if (nfs < 4 || hits < 4) begin errors++; $display("FAIL small_count: got %0d frames expected >=4", nfs); end
    for (int i = 0; i < 300; i++) begin
      tifb.en = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      checks++; if (dvb !== evb) begin errors++; $display("FAIL small_rand: got %h expected %h", dvb, evb); end
    end
    tifb.en = 1'b1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (dva !== 70'd0) begin errors++; $display("FAIL areset_a: got %h expected 0", dva); end
    checks++; if ({tifb.hsync, tifb.vsync, tifb.hcount, tifb.vcount, tifb.de} !== {2'b11, 7'd0})
      begin errors++; $display("FAIL areset_b: got h=%0d v=%0d expected 0,0", tifb.hcount, tifb.vcount); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (dva !== eva) begin errors++; $display("FAIL areset_restart: got %h expected %h", dva, eva); end
    checks++; if ({tifa.hcount, tifa.vcount} !== {10'd2, 10'd0})
      begin errors++; $display("FAIL areset_pos: got %0d,%0d expected 2,0", tifa.hcount, tifa.vcount); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_freeze();
    test_random_en();
    test_resync();
    test_de_window();
    test_small();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
